// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side, memory-map and PPU-register signals around the OAM DMA sequencer.
interface oam_dma_if;
    logic        cpu_ce;
    logic [15:0] cpu_addr_i;
    logic        cpu_wr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_halt;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_i;
    logic        ppu_cs;
    logic        ppu_rw;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_data;
    logic        busy;
    logic        done;

    modport master (
        input  cpu_ce, cpu_addr_i, cpu_wr_i, cpu_data_i, mem_data_i,
        output cpu_halt, mem_addr, mem_rd, ppu_cs, ppu_rw, ppu_addr, ppu_data, busy, done
    );
    modport slave (
        output cpu_ce, cpu_addr_i, cpu_wr_i, cpu_data_i, mem_data_i,
        input  cpu_halt, mem_addr, mem_rd, ppu_cs, ppu_rw, ppu_addr, ppu_data, busy, done
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: NES $4014 sprite DMA; halts the CPU and copies one 256-byte page
// into the PPU through OAMDATA, one byte per read/write CPU-cycle pair.
module oam_dma #(
    parameter logic [15:0] DMA_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_REG  = 3'h4,
    parameter int          CNT_W    = 8
) (
    input logic       clk,
    input logic       rst,
    oam_dma_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [7:0]       page_q, page_d;
    logic             parity_q;
    logic             trig, last;
    logic             done_q, mem_rd_q, ppu_cs_q, ppu_rw_q;
    logic [15:0]      mem_addr_q;
    logic [2:0]       ppu_addr_q;
    logic [7:0]       ppu_data_q;

    // Reads must land on even-parity (get) cycles, so HALT goes straight to READ
    // only when the cycle after it is even.
    always_comb begin
        trig    = bus.cpu_wr_i && (bus.cpu_addr_i == DMA_ADDR);
        last    = &idx_q;
        state_d = (state_q == IDLE)  ? (trig ? HALT : IDLE) :
                  (state_q == HALT)  ? (parity_q ? READ : ALIGN) :
                  (state_q == ALIGN) ? READ :
                  (state_q == READ)  ? WRITE :
                  (last ? IDLE : READ);
        page_d  = (state_q == IDLE && trig) ? bus.cpu_data_i : page_q;
        idx_d   = (state_q == WRITE) ? idx_q + CNT_W'(1) : idx_q;
    end

    // The byte latched at the end of READ is held directly in ppu_data_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            page_q     <= 8'h00;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            ppu_cs_q   <= 1'b0;
            ppu_rw_q   <= 1'b1;
            ppu_addr_q <= 3'h0;
            ppu_data_q <= 8'h00;
        end else begin
            done_q <= bus.cpu_ce && (state_q == WRITE) && last;
            if (bus.cpu_ce) begin
                state_q    <= state_d;
                idx_q      <= idx_d;
                page_q     <= page_d;
                parity_q   <= ~parity_q;
                mem_rd_q   <= state_d == READ;
                mem_addr_q <= (state_d == READ) ? 16'({page_d, idx_d}) : 16'h0000;
                ppu_cs_q   <= state_d == WRITE;
                ppu_rw_q   <= state_d != WRITE;
                ppu_addr_q <= (state_d == WRITE) ? OAM_REG : 3'h0;
                ppu_data_q <= (state_d == WRITE) ? bus.mem_data_i : 8'h00;
            end
        end
    end

    assign bus.cpu_halt = state_q != IDLE;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ppu_cs   = ppu_cs_q;
    assign bus.ppu_rw   = ppu_rw_q;
    assign bus.ppu_addr = ppu_addr_q;
    assign bus.ppu_data = ppu_data_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized-memory bench for oam_dma, checked against a page-copy
// model built from a CPU memory array and the per-trigger cycle-count rules.
module tb_oam_dma;
    logic clk = 1'b0;
    logic rst = 1'b1;
    oam_dma_if bus();
    oam_dma dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [32:0] RST_OUTS = {1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'h0, 8'h00, 1'b0, 1'b0};

    logic [7:0]  mem [0:65535];
    assign bus.mem_data_i = mem[bus.mem_addr];

    int total = 0, bad = 0;
    int div = 1, ce_count = 0;
    int halt_cyc, done_cnt, attr_bad, width_bad, stable_bad, cs_w;
    logic prev_cs = 1'b0, prev_ce = 1'b0;
    logic [31:0] snap, prev_snap = '0;
    logic [7:0]  wq[$];
    logic [15:0] aq[$];

    function automatic logic [32:0] outs();
        return {bus.cpu_halt, bus.mem_rd, bus.mem_addr, bus.ppu_cs, bus.ppu_rw,
                bus.ppu_addr, bus.ppu_data, bus.busy, bus.done};
    endfunction

    // cpu_ce driver; ce_count is the number of CPU cycles completed since reset
    initial begin
        int cnt;
        cnt = 0;
        bus.cpu_ce = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (rst) ce_count = 0;
            else if (bus.cpu_ce) ce_count++;
            cnt++;
            bus.cpu_ce = (cnt % div) == 0;
        end
    end

    // observer: collects writes, read addresses, halted cycles and timing violations
    initial forever begin
        @(negedge clk);
        snap = {bus.cpu_halt, bus.mem_rd, bus.mem_addr, bus.ppu_cs, bus.ppu_rw,
                bus.ppu_addr, bus.ppu_data, bus.busy};
        if (!rst) begin
            if (bus.cpu_ce && bus.cpu_halt) halt_cyc++;
            if (bus.cpu_ce && bus.mem_rd) aq.push_back(bus.mem_addr);
            if (bus.done) done_cnt++;
            if (bus.ppu_cs && !prev_cs) begin
                wq.push_back(bus.ppu_data);
                cs_w = 1;
                if (bus.ppu_addr !== 3'd4 || bus.ppu_rw !== 1'b0) attr_bad++;
            end else if (bus.ppu_cs) cs_w++;
            else if (prev_cs && cs_w != div) width_bad++;
            if (!prev_ce && snap !== prev_snap) stable_bad++;
        end
        prev_cs   = bus.ppu_cs;
        prev_ce   = bus.cpu_ce;
        prev_snap = snap;
    end

    function automatic int data_err(input logic [7:0] page);
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (i >= wq.size() || wq[i] !== mem[{page, 8'(i)}]) n++;
        return n;
    endfunction

    function automatic int addr_err(input logic [7:0] page);
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (i >= aq.size() || aq[i] !== 16'(page * 256 + i)) n++;
        return n;
    endfunction

    task automatic clear_mon();
        halt_cyc = 0; done_cnt = 0; attr_bad = 0; width_bad = 0; stable_bad = 0;
        wq.delete(); aq.delete();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic wr);
        int n = 0;
        do begin @(posedge clk); #3; n++; end while (!bus.cpu_ce && n < 10);
        bus.cpu_wr_i = wr; bus.cpu_addr_i = a; bus.cpu_data_i = d;
        @(posedge clk); #3;
        bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 16'h0000; bus.cpu_data_i = 8'h00;
    endtask

    // trigger so that the trigger CPU cycle has the requested parity
    task automatic fire(input logic [7:0] page, input int want);
        int n = 0;
        do begin @(posedge clk); #3; n++; end
        while (!(bus.cpu_ce && !rst && (ce_count % 2) == want) && n < 100);
        bus.cpu_wr_i = 1'b1; bus.cpu_addr_i = 16'h4014; bus.cpu_data_i = page;
        @(posedge clk); #3;
        bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 16'h0000; bus.cpu_data_i = 8'h00;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 2000 * div) begin
            @(posedge clk); #3; n++;
            if (done_cnt != 0) begin ok = 1'b1; break; end
        end
        repeat (4 * div) @(posedge clk);
        #3;
    endtask

    task automatic wait_writes(input int cnt, output bit ok);
        int n = 0;
        while (wq.size() < cnt && n < 2000) begin @(posedge clk); #3; n++; end
        ok = wq.size() >= cnt;
    endtask

    task automatic run(input logic [7:0] page, input int want, output bit ok);
        clear_mon();
        fire(page, want);
        wait_done(ok);
    endtask

    task automatic test_reset();
        #12;
        total++; if (outs() !== RST_OUTS) begin bad++; $display("FAIL reset_outs: got %h expected %h", outs(), RST_OUTS); end
        @(posedge clk); #4 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        total++; if (outs() !== RST_OUTS) begin bad++; $display("FAIL idle_outs: got %h expected %h", outs(), RST_OUTS); end
    endtask

    task automatic test_even();
        bit ok;
        run(8'h02, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL even_done: got 0 expected 1"); end
        total++; if (halt_cyc !== 513) begin bad++; $display("FAIL even_halt: got %0d expected 513", halt_cyc); end
        total++; if (wq.size() !== 256) begin bad++; $display("FAIL even_writes: got %0d expected 256", wq.size()); end
        total++; if (data_err(8'h02) !== 0) begin bad++; $display("FAIL even_data: got %0d bad bytes expected 0", data_err(8'h02)); end
        total++; if (attr_bad !== 0) begin bad++; $display("FAIL even_attr: got %0d expected 0", attr_bad); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL even_done_cnt: got %0d expected 1", done_cnt); end
        total++; if (bus.busy !== 1'b0 || bus.cpu_halt !== 1'b0) begin bad++; $display("FAIL even_busy_after: got %b%b expected 00", bus.busy, bus.cpu_halt); end
    endtask

    task automatic test_odd();
        bit ok;
        run(8'h02, 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL odd_done: got 0 expected 1"); end
        total++; if (halt_cyc !== 514) begin bad++; $display("FAIL odd_halt: got %0d expected 514", halt_cyc); end
        total++; if (data_err(8'h02) !== 0 || wq.size() !== 256) begin bad++; $display("FAIL odd_data: got %0d bad of %0d expected 0 of 256", data_err(8'h02), wq.size()); end
    endtask

    task automatic test_slow_ce();
        bit ok;
        div = 3;
        run(8'h02, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL slow_done: got 0 expected 1"); end
        total++; if (halt_cyc !== 513) begin bad++; $display("FAIL slow_halt: got %0d expected 513", halt_cyc); end
        total++; if (data_err(8'h02) !== 0 || wq.size() !== 256) begin bad++; $display("FAIL slow_data: got %0d bad of %0d expected 0 of 256", data_err(8'h02), wq.size()); end
        total++; if (width_bad !== 0) begin bad++; $display("FAIL slow_cs_width: got %0d bad pulses expected 0", width_bad); end
        total++; if (stable_bad !== 0) begin bad++; $display("FAIL slow_stable: got %0d changes expected 0", stable_bad); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL slow_done_cnt: got %0d expected 1", done_cnt); end
        div = 1;
        repeat (6) @(posedge clk);
        #3;
    endtask

    task automatic test_ignore();
        bit ok;
        clear_mon();
        fire(8'h02, 0);
        wait_writes(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_progress: got %0d writes expected 50", wq.size()); end
        cpu_write(16'h4014, 8'h03, 1'b1);
        wait_done(ok);
        total++; if (halt_cyc !== 513) begin bad++; $display("FAIL ign_halt: got %0d expected 513", halt_cyc); end
        total++; if (data_err(8'h02) !== 0 || wq.size() !== 256) begin bad++; $display("FAIL ign_data: got %0d bad of %0d expected 0 of 256", data_err(8'h02), wq.size()); end
        total++; if (addr_err(8'h02) !== 0) begin bad++; $display("FAIL ign_addr: got %0d bad expected 0", addr_err(8'h02)); end
        clear_mon();
        cpu_write(16'h4014, 8'h03, 1'b0);
        cpu_write(16'h4015, 8'h03, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        total++; if (halt_cyc !== 0 || bus.busy !== 1'b0 || done_cnt !== 0) begin bad++; $display("FAIL ign_idle: got halt=%0d busy=%b done=%0d expected 0 0 0", halt_cyc, bus.busy, done_cnt); end
    endtask

    task automatic test_async_rst();
        bit ok;
        clear_mon();
        fire(8'h02, 1);
        wait_writes(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_progress: got %0d writes expected 100", wq.size()); end
        #4 rst = 1'b1;
        #1;
        total++; if (outs() !== RST_OUTS) begin bad++; $display("FAIL rst_async: got %h expected %h", outs(), RST_OUTS); end
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        run(8'h03, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_restart_done: got 0 expected 1"); end
        total++; if (data_err(8'h03) !== 0 || wq.size() !== 256) begin bad++; $display("FAIL rst_restart_data: got %0d bad of %0d expected 0 of 256", data_err(8'h03), wq.size()); end
        total++; if (addr_err(8'h03) !== 0) begin bad++; $display("FAIL rst_restart_addr: got %0d bad expected 0", addr_err(8'h03)); end
        total++; if (halt_cyc !== 513) begin bad++; $display("FAIL rst_restart_halt: got %0d expected 513", halt_cyc); end
    endtask

    task automatic test_page_ff();
        bit ok;
        run(8'hFF, 0, ok);
        total++; if (addr_err(8'hFF) !== 0 || aq.size() !== 256) begin bad++; $display("FAIL ff_addr: got %0d bad of %0d expected 0 of 256", addr_err(8'hFF), aq.size()); end
        total++; if (data_err(8'hFF) !== 0) begin bad++; $display("FAIL ff_data: got %0d bad expected 0", data_err(8'hFF)); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        run(8'h02, 1, ok);
        total++; if (aq.size() == 0 || aq[0] !== 16'h0200) begin bad++; $display("FAIL b2b_first_addr: got %h expected 0200", aq.size() ? aq[0] : 16'hxxxx); end
        total++; if (halt_cyc !== 514 || data_err(8'h02) !== 0) begin bad++; $display("FAIL b2b: got halt=%0d bad=%0d expected 514 0", halt_cyc, data_err(8'h02)); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 16'h0000; bus.cpu_data_i = 8'h00;
        test_reset();
        test_even();
        test_odd();
        test_slow_ce();
        test_ignore();
        test_async_rst();
        test_page_ff();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sequencer for the PPU CPU-side register port; implements the NES OAM DMA at $4014.
- On a CPU write to $4014 it halts the CPU and reads 256 bytes from CPU page {data,8'h00}.
- Each byte is written into the PPU through register 4 (OAMDATA), on the same cpu_cs/cpu_rw/cpu_addr/cpu_data_i strobe the CPU uses.
- Sits between the CPU core, the CPU memory map and the ppu register interface, and owns that interface while busy.

Parameters:
- DMA_ADDR, 16'h4014, CPU address whose write triggers a transfer.
- OAM_REG, 3'h4, PPU register index written for each byte.
- CNT_W, 8, byte-index width; transfer length is 2**CNT_W bytes.

Ports:
- clk  in  1  system clock (PPU rate).
- rst  in  1  asynchronous, active-high reset.
- cpu_ce  in  1  CPU-cycle enable; one clk-wide pulse per CPU cycle. All state advances only when cpu_ce=1.
- cpu_addr_i  in  16  CPU bus address.
- cpu_wr_i  in  1  CPU write strobe, valid when cpu_ce=1.
- cpu_data_i  in  8  CPU write data; the page number on the trigger write.
- cpu_halt  out  1  CPU stall request; the CPU holds while high.
- mem_addr  out  16  DMA read address to the CPU memory map.
- mem_rd  out  1  DMA read request.
- mem_data_i  in  8  read data, valid at the cpu_ce that ends a READ cycle.
- ppu_cs  out  1  PPU register chip select (muxed with the CPU by the top level when cpu_halt=1).
- ppu_rw  out  1  1=read, 0=write.
- ppu_addr  out  3  PPU register index.
- ppu_data  out  8  PPU register write data.
- busy  out  1  high from trigger until return to IDLE.
- done  out  1  one-clk pulse on completion.

Behaviour:
- Reset (async): state IDLE, idx=0, page=0, parity=0.
- Reset values of outputs: cpu_halt=0, mem_rd=0, mem_addr=0, ppu_cs=0, ppu_rw=1, ppu_addr=0, ppu_data=0, busy=0, done=0.
- parity: toggles on every cpu_ce since reset. Even (0) = get cycle.
- Trigger: in IDLE, cpu_ce & cpu_wr_i & cpu_addr_i==DMA_ADDR latches page=cpu_data_i and goes to HALT.
- No trigger from reads, other addresses, or any write while not IDLE; those are ignored.
- States and transitions (each state lasts exactly one CPU cycle, i.e. ce to ce):
  - HALT (dummy): next state is READ if parity after this ce is even, else ALIGN.
  - ALIGN: next state READ.
  - READ: mem_rd=1, mem_addr={page,idx}. At the closing ce, latch byte=mem_data_i; next state WRITE.
  - WRITE: ppu_cs=1, ppu_rw=0, ppu_addr=OAM_REG, ppu_data=byte. At the closing ce:
    - if idx==2**CNT_W-1, go IDLE, idx wraps to 0, done pulses for one clk;
    - otherwise idx+1 and go READ.
- ppu_cs is low in every non-WRITE state, so each byte produces exactly one cs assertion.
- Outputs are registered and held constant across clks with cpu_ce=0.
- cpu_halt=busy=1 in HALT/ALIGN/READ/WRITE, rising the clk after the trigger ce.
- Halted CPU cycles: 513 when the trigger lands on an even-parity cycle, 514 when it lands on an odd-parity cycle.
- Reset mid-transfer: immediate return to reset values. No partial resume; the next trigger restarts at idx 0.
- No OAMADDR handling. The PPU auto-increments its own OAM pointer.

Test Plan:
1. mem[0x0200+i]=i^8'hA5; trigger write 8'h02 to 0x4014 on an even-parity cycle, cpu_ce every clk -> cpu_halt high for 513 ce-cycles; 256 ppu_cs pulses with ppu_addr=4, ppu_rw=0, data sequence 8'hA5,8'hA4,...; done pulses once; busy=0 afterwards.
2. Same transfer but triggered on an odd-parity cycle -> 514 halted cycles, identical data sequence.
3. cpu_ce asserted every 3rd clk -> identical counts and data; ppu_cs width = 3 clks per write; outputs stable between ces.
4. Second write of 8'h03 to 0x4014 during byte 50, plus a read of 0x4014 and a write to 0x4015 while idle -> no restart, page stays 8'h02, no trigger from the read or 0x4015 write.
5. Assert rst asynchronously (mid-clk) during byte 100 -> all outputs at reset values immediately; a new trigger with page 8'h03 reads from 0x0300 starting at idx 0.
6. Page 8'hFF -> mem_addr runs 0xFF00..0xFFFF with no carry into bits above the page; idx wraps to 0 at completion.
